// File: rtl/shift_window_pkg.sv
// Shared constants, fill-counter width helper and view-mode enum for shift_window_reg.
package shift_window_pkg;

  parameter int unsigned SW_DATA_W_DEF = 8;
  parameter int unsigned SW_DEPTH_DEF  = 4;

  // Fill counter must hold values 0..depth inclusive.
  function automatic int unsigned sw_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic {
    SW_VIEW_WINDOW = 1'b0,
    SW_VIEW_FINAL  = 1'b1
  } sw_view_e;

endpackage

// File: rtl/shift_window_fill_ctr.sv
// Saturating fill counter for shift_window_reg, with clear-and-load-1 and a
// registered pulse flagging that a shift evicted a valid oldest entry.
module shift_window_fill_ctr #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  output logic [CNT_W-1:0] fill,
  output logic             full,
  output logic             shift_drop
);

  localparam logic [CNT_W-1:0] FillMax = CNT_W'(DEPTH);

  logic [CNT_W-1:0] fill_q, fill_d;
  logic             drop_q, drop_d;

  // Next-state: clear wins over shift; a shift while full drops the oldest entry.
  always_comb begin
    fill_d = fill_q;
    drop_d = 1'b0;
    if (clear) begin
      fill_d = shift ? CNT_W'(1) : '0;
    end else if (shift) begin
      drop_d = full;
      if (!full) fill_d = fill_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
      drop_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      drop_q <= drop_d;
    end
  end

  assign fill       = fill_q;
  assign full       = (fill_q == FillMax);
  assign shift_drop = drop_q;

endmodule

// File: rtl/shift_window_reg.sv
// DEPTH-entry, DATA_W-bit shift window: entry DEPTH-1 newest, entry 0 oldest.
// Optional feature macro: SHIFT_WINDOW_ROTATE_EN adds a 'rotate' input that
// rotates the window by one entry when neither clear nor shift is active.
module shift_window_reg
  import shift_window_pkg::*;
#(
  parameter int unsigned DATA_W = SW_DATA_W_DEF,
  parameter int unsigned DEPTH  = SW_DEPTH_DEF,
  parameter int unsigned CNT_W  = sw_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
`ifdef SHIFT_WINDOW_ROTATE_EN
  input  logic              rotate,
`endif
  input  logic [DATA_W-1:0] inp,
  input  logic              final_output,
  output logic [DATA_W-1:0] outp [0:DEPTH-1],
  output logic [CNT_W-1:0]  fill,
  output logic              full,
  output logic              shift_drop
);

  logic [DATA_W-1:0] win_q [DEPTH];
  logic [DATA_W-1:0] win_d [DEPTH];
  sw_view_e          view;

  // Window next-state; priority clear > shift (> rotate when enabled).
  always_comb begin
    win_d = win_q;
    if (clear) begin
      for (int unsigned k = 0; k < DEPTH; k++) win_d[k] = '0;
      if (shift) win_d[DEPTH-1] = inp;
    end else if (shift) begin
      for (int unsigned k = 0; k < DEPTH - 1; k++) win_d[k] = win_q[k+1];
      win_d[DEPTH-1] = inp;
    end
`ifdef SHIFT_WINDOW_ROTATE_EN
    else if (rotate) begin
      for (int unsigned k = 0; k < DEPTH - 1; k++) win_d[k] = win_q[k+1];
      win_d[DEPTH-1] = win_q[0];
    end
`endif
  end

  // Window storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) win_q[k] <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  shift_window_fill_ctr #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fill_ctr (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .shift      (shift),
    .fill       (fill),
    .full       (full),
    .shift_drop (shift_drop)
  );

  assign view = sw_view_e'(final_output);

  // Output view: full window, or newest entry alone on outp[0].
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) outp[k] = '0;
    unique case (view)
      SW_VIEW_FINAL:  outp[0] = win_q[DEPTH-1];
      SW_VIEW_WINDOW: begin
        for (int unsigned k = 0; k < DEPTH; k++) outp[k] = win_q[k];
      end
      default: ;
    endcase
  end

endmodule
